// File: rtl/cache_pkg.sv
// Shared state encoding and address-field width helpers for the set-associative cache.
package cache_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLookup,
      StWback,
      StFill,
      StResp,
      StFlushScan,
      StFlushWb
   } state_e;

   // Index width that never collapses to zero bits.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   function automatic int unsigned off_w(input int unsigned line_bytes);
      return $clog2(line_bytes);
   endfunction

   function automatic int unsigned idx_w(input int unsigned sets);
      return $clog2(sets);
   endfunction

   function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets,
                                         input int unsigned line_bytes);
      return addr_w - idx_w(sets) - off_w(line_bytes);
   endfunction

endpackage

// File: rtl/cache_way_ram.sv
// One cache way: tag and line storage, single port, one-cycle registered read, byte writes.
module cache_way_ram #(
   parameter int unsigned IDX_W      = 8,
   parameter int unsigned TAG_W      = 20,
   parameter int unsigned LINE_BYTES = 16
) (
   input  logic                    clk,
   input  logic [IDX_W-1:0]        idx,
   input  logic                    tag_we,
   input  logic [TAG_W-1:0]        tag_wdata,
   input  logic [LINE_BYTES-1:0]   be,
   input  logic [LINE_BYTES*8-1:0] wdata,
   output logic [TAG_W-1:0]        tag_rdata,
   output logic [LINE_BYTES*8-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** IDX_W;

   logic [TAG_W-1:0]            tag_mem  [DEPTH];
   logic [LINE_BYTES-1:0][7:0]  data_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (tag_we) tag_mem[idx] <= tag_wdata;
      for (int b = 0; b < int'(LINE_BYTES); b++) begin
         if (be[b]) data_mem[idx][b] <= wdata[8*b +: 8];
      end
      tag_rdata <= tag_mem[idx];
      rdata     <= data_mem[idx];
   end

endmodule

// File: rtl/cache_assoc.sv
// N-way set-associative write-back, write-allocate cache with flush-all and per-set pointer.
module cache_assoc
   import cache_pkg::*;
#(
   parameter int unsigned WAYS       = 2,
   parameter int unsigned SETS       = 256,
   parameter int unsigned LINE_BYTES = 16,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid,
   output logic                    ready,
   input  logic [ADDR_W-1:0]       addr,
   input  logic [3:0]              wmask,
   input  logic [31:0]             wdata,
   output logic [31:0]             rdata,
   input  logic                    flush_req,
   output logic                    flush_done,
   output logic                    mem_valid,
   input  logic                    mem_ready,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic                    mem_we,
   output logic [LINE_BYTES*8-1:0] mem_wdata,
   input  logic [LINE_BYTES*8-1:0] mem_rdata
);

   localparam int unsigned OFF_W  = off_w(LINE_BYTES);
   localparam int unsigned IDX_W  = idx_w(SETS);
   localparam int unsigned TAG_W  = tag_w(ADDR_W, SETS, LINE_BYTES);
   localparam int unsigned LINE_W = LINE_BYTES * 8;
   localparam int unsigned WORDS  = LINE_BYTES / 4;
   localparam int unsigned WSEL_W = clog2_min1(WORDS);
   localparam int unsigned WAY_W  = clog2_min1(WAYS);

   state_e                          state;
   logic [SETS-1:0][WAYS-1:0]       valid_q, dirty_q;
   logic [SETS-1:0][WAY_W-1:0]      ptr_q;
   logic [WAY_W-1:0]                way_q;
   logic [IDX_W-1:0]                cnt_q;

   logic [IDX_W-1:0]  req_idx, ram_idx;
   logic [TAG_W-1:0]  req_tag;
   logic [WSEL_W-1:0] req_word;
   int unsigned       word_lsb;
   logic [TAG_W-1:0]  tag_rd  [WAYS];
   logic [LINE_W-1:0] data_rd [WAYS];

   logic              hit, inv_found, fl_dirty;
   logic [WAY_W-1:0]  hit_way, inv_way, victim, fl_way;
   logic              fill_hs, mem_hs, resp_wr, tag_we;
   logic [LINE_BYTES-1:0] ram_be;
   logic [LINE_W-1:0] ram_wdata;

   assign req_idx  = IDX_W'(addr >> OFF_W);
   assign req_tag  = TAG_W'(addr >> (OFF_W + IDX_W));
   assign req_word = WSEL_W'((addr >> 2) & ADDR_W'(WORDS - 1));
   assign word_lsb = 32'(req_word) * 32;
   assign ram_idx  = (state == StFlushScan || state == StFlushWb) ? cnt_q : req_idx;

   assign mem_hs    = mem_valid && mem_ready;
   assign fill_hs   = (state == StFill) && mem_hs;
   assign resp_wr   = (state == StResp) && (wmask != 4'b0);
   assign tag_we    = fill_hs;
   assign ram_wdata = fill_hs ? mem_rdata : {WORDS{wdata}};
   assign ram_be    = fill_hs ? '1 :
                      resp_wr ? (LINE_BYTES'(wmask) << (4 * 32'(req_word))) : '0;

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic sel;
      assign sel = (way_q == WAY_W'(w));
      cache_way_ram #(
         .IDX_W      (IDX_W),
         .TAG_W      (TAG_W),
         .LINE_BYTES (LINE_BYTES)
      ) u_ram (
         .clk       (clk),
         .idx       (ram_idx),
         .tag_we    (tag_we && sel),
         .tag_wdata (req_tag),
         .be        (sel ? ram_be : '0),
         .wdata     (ram_wdata),
         .tag_rdata (tag_rd[w]),
         .rdata     (data_rd[w])
      );
   end

   // Descending scan so the lowest-numbered matching way wins.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      fl_dirty  = 1'b0;
      fl_way    = '0;
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (valid_q[req_idx][w] && tag_rd[w] == req_tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[req_idx][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
         if (dirty_q[cnt_q][w]) begin
            fl_dirty = 1'b1;
            fl_way   = WAY_W'(w);
         end
      end
      victim = inv_found ? inv_way : ptr_q[req_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StIdle;
         ready      <= 1'b0;
         rdata      <= '0;
         flush_done <= 1'b0;
         mem_valid  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         valid_q    <= '0;
         dirty_q    <= '0;
         ptr_q      <= '0;
         way_q      <= '0;
         cnt_q      <= '0;
      end else begin
         ready      <= 1'b0;
         flush_done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (valid && !ready) begin
                  state <= StLookup;
               end else if (flush_req && !flush_done) begin
                  cnt_q <= '0;
                  state <= StFlushScan;
               end
            end
            StLookup: begin
               if (hit) begin
                  way_q <= hit_way;
                  rdata <= data_rd[hit_way][word_lsb +: 32];
                  ready <= 1'b1;
                  state <= StResp;
               end else begin
                  way_q     <= victim;
                  mem_valid <= 1'b1;
                  if (dirty_q[req_idx][victim]) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= {tag_rd[victim], req_idx, {OFF_W{1'b0}}};
                     mem_wdata <= data_rd[victim];
                     state     <= StWback;
                  end else begin
                     mem_we   <= 1'b0;
                     mem_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
                     state    <= StFill;
                  end
               end
            end
            StWback: begin
               if (mem_hs) begin
                  mem_valid               <= 1'b0;
                  dirty_q[req_idx][way_q] <= 1'b0;
                  state                   <= StFill;
               end
            end
            StFill: begin
               // After a write-back the fill is issued one cycle later, never back-to-back.
               if (mem_hs) begin
                  mem_valid               <= 1'b0;
                  valid_q[req_idx][way_q] <= 1'b1;
                  rdata                   <= mem_rdata[word_lsb +: 32];
                  ready                   <= 1'b1;
                  state                   <= StResp;
               end else if (!mem_valid) begin
                  mem_valid <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= {req_tag, req_idx, {OFF_W{1'b0}}};
               end
            end
            StResp: begin
               if (wmask != 4'b0) dirty_q[req_idx][way_q] <= 1'b1;
               ptr_q[req_idx] <= (way_q == WAY_W'(WAYS - 1)) ? '0 : way_q + 1'b1;
               state          <= StIdle;
            end
            StFlushScan: begin
               if (fl_dirty) begin
                  way_q <= fl_way;
                  state <= StFlushWb;
               end else if (cnt_q == IDX_W'(SETS - 1)) begin
                  flush_done <= 1'b1;
                  state      <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StFlushWb: begin
               if (mem_hs) begin
                  mem_valid             <= 1'b0;
                  dirty_q[cnt_q][way_q] <= 1'b0;
                  state                 <= StFlushScan;
               end else if (!mem_valid) begin
                  mem_valid <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= {tag_rd[way_q], cnt_q, {OFF_W{1'b0}}};
                  mem_wdata <= data_rd[way_q];
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_assoc.sv
// Directed bench: default 2-way cache plus a 4-way/64-set/32-byte-line instance.
module tb_cache_assoc;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         valid, ready, flush_req, flush_done;
   logic [31:0]  addr, wdata, rdata;
   logic [3:0]   wmask;
   logic         mem_valid, mem_ready, mem_we;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;

   logic         b_valid, b_ready, b_flush_req, b_flush_done;
   logic [31:0]  b_addr, b_wdata, b_rdata;
   logic [3:0]   b_wmask;
   logic         b_mem_valid, b_mem_ready, b_mem_we;
   logic [31:0]  b_mem_addr;
   logic [255:0] b_mem_wdata, b_mem_rdata;

   int n_checks = 0;
   int n_errors = 0;
   int fd_cnt   = 0;
   int ev_base  = 0;
   logic mem_en;

   logic [127:0] mem_a [logic [31:0]];
   logic [31:0]  ev_addr [$];
   logic         ev_we   [$];
   logic [127:0] ev_data [$];
   logic [31:0]  b_ev    [$];

   always #5 clk = ~clk;

   cache_assoc dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid      (valid),
      .ready      (ready),
      .addr       (addr),
      .wmask      (wmask),
      .wdata      (wdata),
      .rdata      (rdata),
      .flush_req  (flush_req),
      .flush_done (flush_done),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   cache_assoc #(
      .WAYS       (4),
      .SETS       (64),
      .LINE_BYTES (32),
      .ADDR_W     (32)
   ) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid      (b_valid),
      .ready      (b_ready),
      .addr       (b_addr),
      .wmask      (b_wmask),
      .wdata      (b_wdata),
      .rdata      (b_rdata),
      .flush_req  (b_flush_req),
      .flush_done (b_flush_done),
      .mem_valid  (b_mem_valid),
      .mem_ready  (b_mem_ready),
      .mem_addr   (b_mem_addr),
      .mem_we     (b_mem_we),
      .mem_wdata  (b_mem_wdata),
      .mem_rdata  (b_mem_rdata)
   );

   always @(posedge clk) if (flush_done) fd_cnt <= fd_cnt + 1;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory for the 2-way instance: one-cycle accept, unknown lines read as zero.
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_en && mem_valid && !mem_ready) begin
            mem_ready = 1'b1;
            if (mem_we) mem_a[mem_addr] = mem_wdata;
            else mem_rdata = mem_a.exists(mem_addr) ? mem_a[mem_addr] : '0;
            ev_addr.push_back(mem_addr);
            ev_we.push_back(mem_we);
            ev_data.push_back(mem_wdata);
         end else begin
            mem_ready = 1'b0;
         end
      end
   end

   // Memory for the 4-way instance: word k of a line is line_address | k.
   initial begin
      b_mem_ready = 1'b0;
      b_mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (b_mem_valid && !b_mem_ready) begin
            b_mem_ready = 1'b1;
            for (int k = 0; k < 8; k++) b_mem_rdata[32*k +: 32] = b_mem_addr | 32'(k);
            b_ev.push_back(b_mem_addr);
         end else begin
            b_mem_ready = 1'b0;
         end
      end
   end

   task automatic rd_a(input string t, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] d, input logic [31:0] exp_rd, input int exp_ev,
                       input int exp_cyc);
      int n0, cyc;
      logic [31:0] rd;
      logic again;
      n0  = ev_addr.size();
      cyc = 0;
      rd  = '0;
      @(negedge clk);
      valid = 1'b1; addr = a; wmask = m; wdata = d;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (ready) begin
            cyc = i;
            rd  = rdata;
            break;
         end
      end
      @(posedge clk); #1;
      again = ready;
      valid = 1'b0; wmask = 4'b0;
      ev_base = n0;
      check({t, "_ready"}, cyc != 0, 1);
      check({t, "_ready_once"}, again, 0);
      if (m == 4'b0) check({t, "_rdata"}, rd, exp_rd);
      check({t, "_mem_ops"}, ev_addr.size() - n0, exp_ev);
      if (exp_cyc != 0) check({t, "_latency"}, cyc, exp_cyc);
   endtask

   task automatic rd_b(input string t, input logic [31:0] a, input logic [31:0] exp_rd,
                       input int exp_ev);
      int n0, cyc;
      logic [31:0] rd;
      n0  = b_ev.size();
      cyc = 0;
      rd  = '0;
      @(negedge clk);
      b_valid = 1'b1; b_addr = a;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (b_ready) begin
            cyc = i;
            rd  = b_rdata;
            break;
         end
      end
      @(posedge clk); #1;
      b_valid = 1'b0;
      ev_base = n0;
      check({t, "_ready"}, cyc != 0, 1);
      check({t, "_rdata"}, rd, exp_rd);
      check({t, "_mem_ops"}, b_ev.size() - n0, exp_ev);
   endtask

   task automatic do_flush(input string t, input int exp_ev);
      int n0, f0;
      logic seen;
      n0   = ev_addr.size();
      f0   = fd_cnt;
      seen = 1'b0;
      @(negedge clk);
      flush_req = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (flush_done) begin
            seen = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      flush_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      ev_base = n0;
      check({t, "_done_seen"}, seen, 1);
      check({t, "_done_pulses"}, fd_cnt - f0, 1);
      check({t, "_mem_ops"}, ev_addr.size() - n0, exp_ev);
   endtask

   initial begin
      logic seen;
      valid = 1'b0; addr = '0; wmask = '0; wdata = '0; flush_req = 1'b0;
      b_valid = 1'b0; b_addr = '0; b_wmask = '0; b_wdata = '0; b_flush_req = 1'b0;
      mem_en = 1'b1;
      rst_n  = 1'b1;
      mem_a[32'h1000] = 128'h44444444_33333333_22222222_11111111;
      mem_a[32'h2000] = 128'h22220003_22220002_22220001_22220000;
      mem_a[32'h3000] = 128'h33330003_33330002_33330001_33330000;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", ready, 0);
      check("rst_flush_done", flush_done, 0);
      check("rst_mem_valid", mem_valid, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_rdata", rdata, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      rst_n = 1'b1;

      rd_a("cold", 32'h1004, 4'h0, 0, 32'h22222222, 1, 3);
      check("cold_fill_addr", ev_addr[ev_base], 32'h1000);
      check("cold_fill_we", ev_we[ev_base], 0);
      rd_a("cold_rehit", 32'h1004, 4'h0, 0, 32'h22222222, 0, 2);

      rd_a("conf_fill2", 32'h2000, 4'h0, 0, 32'h22220000, 1, 0);
      rd_a("conf_hit2", 32'h2000, 4'h0, 0, 32'h22220000, 0, 2);
      rd_a("conf_evict", 32'h3000, 4'h0, 0, 32'h33330000, 1, 0);
      check("conf_evict_addr", ev_addr[ev_base], 32'h3000);
      rd_a("conf_keep", 32'h2000, 4'h0, 0, 32'h22220000, 0, 2);
      rd_a("conf_lost", 32'h1000, 4'h0, 0, 32'h11111111, 1, 0);

      rd_a("dirty_wr", 32'h5000, 4'b0011, 32'hAAAABBBB, 0, 1, 0);
      rd_a("dirty_fill", 32'h2000, 4'h0, 0, 32'h22220000, 1, 0);
      rd_a("dirty_evict", 32'h3000, 4'h0, 0, 32'h33330000, 2, 0);
      check("dirty_wb_addr", ev_addr[ev_base], 32'h5000);
      check("dirty_wb_we", ev_we[ev_base], 1);
      check("dirty_wb_data", ev_data[ev_base], 128'h0000BBBB);
      check("dirty_refill_addr", ev_addr[ev_base+1], 32'h3000);
      check("dirty_refill_we", ev_we[ev_base+1], 0);

      rd_a("wr_hit", 32'h2008, 4'hF, 32'hDEADBEEF, 0, 0, 2);
      rd_a("wr_set5", 32'h1050, 4'hF, 32'hCAFEF00D, 0, 1, 0);
      do_flush("flush", 2);
      check("flush_wb0_addr", ev_addr[ev_base], 32'h2000);
      check("flush_wb0_data", ev_data[ev_base], 128'h22220003_DEADBEEF_22220001_22220000);
      check("flush_wb1_addr", ev_addr[ev_base+1], 32'h1050);
      check("flush_wb1_data", ev_data[ev_base+1], 128'hCAFEF00D);
      rd_a("post_flush0", 32'h2008, 4'h0, 0, 32'hDEADBEEF, 0, 2);
      rd_a("post_flush5", 32'h1050, 4'h0, 0, 32'hCAFEF00D, 0, 2);
      do_flush("flush_clean", 0);

      // Reset while a fill is outstanding.
      @(negedge clk);
      mem_en = 1'b0;
      valid = 1'b1; addr = 32'h4000; wmask = 4'h0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (mem_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("rstmid_fill_issued", seen, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rstmid_mem_valid", mem_valid, 0);
      valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      mem_en = 1'b1;
      rd_a("rstmid_refill", 32'h4000, 4'h0, 0, 32'h0, 1, 0);
      check("rstmid_refill_addr", ev_addr[ev_base], 32'h4000);
      rd_a("rstmid_empty", 32'h2008, 4'h0, 0, 32'hDEADBEEF, 1, 0);

      // 4-way instance, set 3: tags 1..5, word index 7.
      rd_b("w4_t1", 32'h0000087C, 32'h00000867, 1);
      check("w4_t1_addr", b_ev[ev_base], 32'h00000860);
      rd_b("w4_t2", 32'h0000107C, 32'h00001067, 1);
      rd_b("w4_t1_hit", 32'h0000087C, 32'h00000867, 0);
      rd_b("w4_t3", 32'h0000187C, 32'h00001867, 1);
      rd_b("w4_t4", 32'h0000207C, 32'h00002067, 1);
      rd_b("w4_t5", 32'h0000287C, 32'h00002867, 1);
      check("w4_t5_addr", b_ev[ev_base], 32'h00002860);
      rd_b("w4_t2_keep", 32'h0000107C, 32'h00001067, 0);
      rd_b("w4_t3_keep", 32'h0000187C, 32'h00001867, 0);
      rd_b("w4_t4_keep", 32'h0000207C, 32'h00002067, 0);
      rd_b("w4_t1_gone", 32'h0000087C, 32'h00000867, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
